// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the proc decode:
// opcode field values and the sequencer FSM state encoding.
package prog_sequencer_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_IMM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_END   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/prog_sequencer_if.sv
// Instruction bus between the sequencer (master) and the proc datapath (slave).
interface prog_sequencer_if #(
    parameter int DATAWIDTH = 6
) ();

    logic [DATAWIDTH-1:0] DIN;
    logic                 Run;
    logic                 Done;

    modport master (output DIN, output Run, input Done);
    modport slave  (input DIN, input Run, output Done);

endinterface

// File: rtl/prog_sequencer_mem.sv
// Program store: one synchronous write port, two asynchronous read ports
// (opcode word and the following immediate word).
module prog_mem #(
    parameter int DATAWIDTH = 6,
    parameter int DEPTH     = 16,
    parameter int AW        = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr0,
    output logic [DATAWIDTH-1:0] rdata0,
    input  logic [AW-1:0]        raddr1,
    output logic [DATAWIDTH-1:0] rdata1
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/prog_sequencer.sv
// Instruction feeder for the proc datapath: issues one program word per proc
// completion, presents mvi immediates, and watchdogs Done.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int DATAWIDTH = 6,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int TIMEOUT   = 7
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [AW-1:0]        last_addr,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [DATAWIDTH-1:0] prog_wdata,
    prog_sequencer_if.master     proc,
    output logic                 busy,
    output logic                 halted,
    output logic                 err_timeout,
    output logic [AW-1:0]        pc,
    output logic [7:0]           instr_count
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    seq_state_t           state;
    logic [AW-1:0]        last_q;
    logic                 halt_seen;
    logic [WDW-1:0]       wd;
    logic [DATAWIDTH-1:0] word0;
    logic [DATAWIDTH-1:0] word1;
    logic [AW-1:0]        pc_plus1;
    logic [AW-1:0]        pc_step;
    logic                 complete;
    logic                 step_two;
    logic                 last_hit;

    assign pc_plus1 = pc + AW'(1);

    prog_mem #(
        .DATAWIDTH(DATAWIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_mem (
        .clk   (Clock),
        .we    (prog_we & ~busy),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr0(pc),
        .rdata0(word0),
        .raddr1(pc_plus1),
        .rdata1(word1)
    );

    assign busy     = (state != ST_IDLE);
    assign halted   = (state == ST_END);
    assign proc.Run = (state == ST_FETCH);

    always_comb begin
        proc.DIN = '0;
        complete = 1'b0;
        step_two = 1'b0;
        case (state)
            ST_FETCH: proc.DIN = word0;
            ST_IMM: begin
                proc.DIN = word1;
                complete = proc.Done;
                step_two = 1'b1;
            end
            ST_WAIT:  complete = proc.Done;
            default:  ;
        endcase
    end

    // last_addr may fall on either word of a two-word mvi
    assign pc_step  = step_two ? pc + AW'(2) : pc_plus1;
    assign last_hit = (last_q == pc) || (step_two && (last_q == pc_plus1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            instr_count <= '0;
            err_timeout <= 1'b0;
            last_q      <= '0;
            halt_seen   <= 1'b0;
            wd          <= '0;
        end else begin
            if (busy && halt_req) begin
                halt_seen <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    halt_seen <= 1'b0;
                    if (start) begin
                        state       <= ST_FETCH;
                        pc          <= '0;
                        instr_count <= '0;
                        err_timeout <= 1'b0;
                        last_q      <= last_addr;
                    end
                end
                ST_FETCH: begin
                    wd    <= WDW'(1);
                    state <= (word0[DATAWIDTH-1 -: 2] == OP_MVI) ? ST_IMM : ST_WAIT;
                end
                ST_IMM: begin
                    if (!proc.Done) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!proc.Done) begin
                        if (wd == WDW'(TIMEOUT)) begin
                            err_timeout <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            wd <= wd + WDW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (complete) begin
                pc <= pc_step;
                if (instr_count != 8'hFF) begin
                    instr_count <= instr_count + 8'd1;
                end
                state <= (halt_seen || halt_req || last_hit) ? ST_END : ST_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a small behavioural proc model on
// the instruction bus.
module tb_prog_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       halt_req;
    logic [3:0] last_addr;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [5:0] prog_wdata;
    logic       busy;
    logic       halted;
    logic       err_timeout;
    logic [3:0] pc;
    logic [7:0] instr_count;

    int n_cmp  = 0;
    int n_fail = 0;

    prog_sequencer_if #(.DATAWIDTH(6)) bus ();

    prog_sequencer #(
        .DATAWIDTH(6),
        .DEPTH    (16),
        .AW       (4),
        .TIMEOUT  (7)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .start      (start),
        .halt_req   (halt_req),
        .last_addr  (last_addr),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .proc       (bus.master),
        .busy       (busy),
        .halted     (halted),
        .err_timeout(err_timeout),
        .pc         (pc),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // proc model: T0 latches IR on Run; mv/mvi finish in T1, add/sub in T3
    logic       hang;
    logic       proc_clr;
    logic [1:0] op_q;
    logic [1:0] rx_q;
    logic [1:0] ry_q;
    logic [2:0] t;
    logic [5:0] R [4];
    logic       proc_done;

    assign proc_done = !hang && (((t == 3'd1) && !op_q[1]) || ((t == 3'd3) && op_q[1]));
    assign bus.Done  = proc_done;

    always @(posedge clk) begin
        if (rst) begin
            t <= '0;
            for (int i = 0; i < 4; i++) R[i] <= '0;
        end else if (proc_clr) begin
            t <= '0;
        end else if (t == 3'd0) begin
            if (bus.Run) begin
                {op_q, rx_q, ry_q} <= bus.DIN;
                t <= 3'd1;
            end
        end else if (proc_done) begin
            t <= '0;
            case (op_q)
                2'b00: R[rx_q] <= R[ry_q];
                2'b01: R[rx_q] <= bus.DIN;
                2'b10: R[rx_q] <= R[rx_q] + R[ry_q];
                default: R[rx_q] <= R[rx_q] - R[ry_q];
            endcase
        end else if (!hang) begin
            t <= t + 3'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        prog_addr  = a;
        prog_wdata = d;
        prog_we    = 1'b1;
        tick(1);
        prog_we    = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; last_addr = '0;
        prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        hang = 1'b0; proc_clr = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_run", bus.Run, 0);
        check("rst_din", bus.DIN, 0);
        check("rst_pc", pc, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_err", err_timeout, 0);
        check("rst_halted", halted, 0);

        // 1: mvi R0,#5 ; mv R0,R0
        wr(4'd0, 6'b010000); wr(4'd1, 6'b000101); wr(4'd2, 6'b000000);
        last_addr = 4'd2;
        go();
        check("t1_fetch_run", bus.Run, 1);
        check("t1_fetch_din", bus.DIN, 6'b010000);
        check("t1_fetch_busy", busy, 1);
        tick(1);
        check("t1_imm_run", bus.Run, 0);
        check("t1_imm_din", bus.DIN, 5);
        tick(1);
        check("t1_fetch2_run", bus.Run, 1);
        check("t1_fetch2_pc", pc, 2);
        check("t1_r0", R[0], 5);
        tick(2);
        check("t1_halted", halted, 1);
        check("t1_pc", pc, 3);
        check("t1_cnt", instr_count, 2);
        tick(1);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_halted", halted, 0);

        // 2: mvi R1,#3 ; mvi R2,#2 ; add R1,R2 ; sub R1,R2
        wr(4'd0, 6'b010100); wr(4'd1, 6'd3); wr(4'd2, 6'b011000); wr(4'd3, 6'd2);
        wr(4'd4, 6'b100110); wr(4'd5, 6'b110110);
        last_addr = 4'd5;
        go();
        tick(4);
        check("t2_add_run", bus.Run, 1);
        check("t2_add_pc", pc, 4);
        check("t2_add_din", bus.DIN, 6'b100110);
        tick(3);
        check("t2_add_wait_run", bus.Run, 0);
        tick(1);
        check("t2_sub_run", bus.Run, 1);
        check("t2_sub_pc", pc, 5);
        tick(4);
        check("t2_halted", halted, 1);
        check("t2_cnt", instr_count, 4);
        check("t2_pc", pc, 6);
        check("t2_r1", R[1], 3);
        check("t2_r2", R[2], 2);
        tick(1);

        // 3: Done never arrives after add
        wr(4'd0, 6'b100110);
        last_addr = 4'd0;
        hang = 1'b1;
        go();
        tick(7);
        check("t3_last_wait_busy", busy, 1);
        check("t3_last_wait_err", err_timeout, 0);
        tick(1);
        check("t3_busy", busy, 0);
        check("t3_err", err_timeout, 1);
        check("t3_halted", halted, 0);
        tick(3);
        check("t3_run", bus.Run, 0);
        check("t3_err_sticky", err_timeout, 1);
        hang = 1'b0; proc_clr = 1'b1;
        tick(1);
        proc_clr = 1'b0;

        // 4: halt_req mid-add
        wr(4'd0, 6'b100110); wr(4'd1, 6'b000000);
        last_addr = 4'd1;
        go();
        check("t4_err_cleared", err_timeout, 0);
        tick(1);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        tick(1);
        check("t4_done_run", bus.Run, 0);
        tick(1);
        check("t4_halted", halted, 1);
        check("t4_cnt", instr_count, 1);
        check("t4_pc", pc, 1);
        check("t4_r1", R[1], 5);
        tick(1);
        check("t4_busy", busy, 0);
        tick(3);
        check("t4_no_issue", bus.Run, 0);

        // 5: mvi at 15 takes its immediate from address 0
        for (int a = 1; a < 15; a++) wr(4'(a), 6'b000000);
        wr(4'd0, 6'b000111); wr(4'd15, 6'b010000);
        last_addr = 4'd15;
        go();
        tick(30);
        check("t5_fetch_run", bus.Run, 1);
        check("t5_fetch_pc", pc, 15);
        check("t5_fetch_din", bus.DIN, 6'b010000);
        tick(1);
        check("t5_imm_din", bus.DIN, 6'b000111);
        tick(1);
        check("t5_halted", halted, 1);
        check("t5_pc", pc, 1);
        check("t5_cnt", instr_count, 16);
        check("t5_r0", R[0], 7);
        tick(1);

        // 6: writes and start ignored while busy; Reset mid-WAIT
        wr(4'd0, 6'b000000); wr(4'd1, 6'b100110);
        last_addr = 4'd1;
        go();
        tick(2);
        check("t6_fetch2_run", bus.Run, 1);
        check("t6_fetch2_cnt", instr_count, 1);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 6'b111111;
        tick(1);
        start = 1'b0; prog_we = 1'b0;
        check("t6_start_ign_pc", pc, 1);
        check("t6_start_ign_cnt", instr_count, 1);
        check("t6_start_ign_busy", busy, 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_run", bus.Run, 0);
        check("t6_rst_din", bus.DIN, 0);
        check("t6_rst_pc", pc, 0);
        check("t6_rst_cnt", instr_count, 0);
        rst = 1'b0;
        last_addr = 4'd0;
        go();
        check("t6_mem_kept", bus.DIN, 6'b000000);
        tick(2);
        check("t6_halted", halted, 1);
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
